// File: rtl/alu_issue_ctrl.sv
// Issue front-end for the datapath ALU: decodes one RV64 integer instruction per
// handshake, drives registered ALU operands/select, and returns the captured result.
module alu_issue_ctrl #(
  parameter int n = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_b5,
  input  logic [n-1:0] rs1_val,
  input  logic [n-1:0] rs2_val,
  input  logic [n-1:0] imm,
  output logic [n-1:0] alu_data1,
  output logic [n-1:0] alu_data2,
  output logic [3:0]   alu_select,
  input  logic [n-1:0] alu_result,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_result,
  output logic         out_is_branch,
  output logic         out_br_taken,
  output logic         out_illegal
);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_PASS = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       r_state;
  logic         r_is_br, r_br_ne, r_ill;
  logic [3:0]   w_sel;
  logic [n-1:0] w_d1, w_d2;
  logic         w_is_br, w_br_ne, w_ill;

  always_comb begin
    w_sel   = SEL_PASS;
    w_d1    = '0;
    w_d2    = '0;
    w_is_br = 1'b0;
    w_br_ne = 1'b0;
    w_ill   = 1'b0;
    case (opcode)
      7'b0110011: begin
        w_d1 = rs1_val;
        w_d2 = rs2_val;
        case (funct3)
          3'b000:  w_sel = funct7_b5 ? SEL_SUB : SEL_ADD;
          3'b111:  w_sel = SEL_AND;
          3'b110:  w_sel = SEL_OR;
          default: w_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_d1 = rs1_val;
        w_d2 = imm;
        case (funct3)
          3'b000:  w_sel = SEL_ADD;
          3'b111:  w_sel = SEL_AND;
          3'b110:  w_sel = SEL_OR;
          default: w_ill = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        w_sel = SEL_ADD;
        w_d1  = rs1_val;
        w_d2  = imm;
      end
      7'b0110111: w_d2 = imm;
      7'b1100011: begin
        w_sel   = SEL_SUB;
        w_d1    = rs1_val;
        w_d2    = rs2_val;
        w_is_br = 1'b1;
        w_br_ne = funct3[0];
        if (funct3[2:1] != 2'b00) w_ill = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal encodings present a PASS of zero so the ALU output is benign
    if (w_ill) begin
      w_sel   = SEL_PASS;
      w_d1    = '0;
      w_d2    = '0;
      w_is_br = 1'b0;
      w_br_ne = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_is_br       <= 1'b0;
      r_br_ne       <= 1'b0;
      r_ill         <= 1'b0;
      alu_data1     <= '0;
      alu_data2     <= '0;
      alu_select    <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_is_branch <= 1'b0;
      out_br_taken  <= 1'b0;
      out_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          alu_select <= w_sel;
          alu_data1  <= w_d1;
          alu_data2  <= w_d2;
          r_is_br    <= w_is_br;
          r_br_ne    <= w_br_ne;
          r_ill      <= w_ill;
          r_state    <= EXEC;
        end
        EXEC: begin
          out_result    <= r_ill ? '0 : alu_result;
          out_br_taken  <= r_is_br & (alu_zero ^ r_br_ne);
          out_is_branch <= r_is_br;
          out_illegal   <= r_ill;
          out_valid     <= 1'b1;
          r_state       <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by reset so the producer never sees ready while held in reset
  assign in_ready = rst_n && (r_state == IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a behavioural ALU and
// an instruction-level reference model.
module tb_alu_issue_ctrl;
  localparam int N = 64;

  logic         clk = 0, rst_n = 0;
  logic         in_valid = 0, in_ready;
  logic [6:0]   opcode = '0;
  logic [2:0]   funct3 = '0;
  logic         funct7_b5 = 0;
  logic [N-1:0] rs1_val = '0, rs2_val = '0, imm = '0;
  logic [N-1:0] alu_data1, alu_data2, alu_result, out_result;
  logic [3:0]   alu_select;
  logic         alu_zero, out_valid, out_ready = 0;
  logic         out_is_branch, out_br_taken, out_illegal;
  int total = 0, bad = 0;

  alu_issue_ctrl #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_is_branch(out_is_branch), .out_br_taken(out_br_taken), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_select)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      4'b0111: alu_result = alu_data2;
      4'b1100: alu_result = ~(alu_data1 | alu_data2);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  // Instruction-level expectation straight from the ISA semantics
  function automatic void ref_model(input logic [6:0] op, input logic [2:0] f3, input logic b5,
      input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] im,
      output logic [3:0] sel, output logic [N-1:0] d1, output logic [N-1:0] d2,
      output logic [N-1:0] res, output logic isbr, output logic tk, output logic ill);
    ill = 0; isbr = 0; tk = 0; sel = 4'b0111; d1 = '0; d2 = '0; res = '0;
    if (op == 7'b0110011 && f3 == 3'b000 && !b5) begin sel = 4'b0010; d1 = a; d2 = b; res = a + b; end
    else if (op == 7'b0110011 && f3 == 3'b000) begin sel = 4'b0110; d1 = a; d2 = b; res = a - b; end
    else if (op == 7'b0110011 && f3 == 3'b111) begin sel = 4'b0000; d1 = a; d2 = b; res = a & b; end
    else if (op == 7'b0110011 && f3 == 3'b110) begin sel = 4'b0001; d1 = a; d2 = b; res = a | b; end
    else if (op == 7'b0010011 && f3 == 3'b000) begin sel = 4'b0010; d1 = a; d2 = im; res = a + im; end
    else if (op == 7'b0010011 && f3 == 3'b111) begin sel = 4'b0000; d1 = a; d2 = im; res = a & im; end
    else if (op == 7'b0010011 && f3 == 3'b110) begin sel = 4'b0001; d1 = a; d2 = im; res = a | im; end
    else if (op == 7'b0000011 || op == 7'b0100011) begin sel = 4'b0010; d1 = a; d2 = im; res = a + im; end
    else if (op == 7'b0110111) begin d2 = im; res = im; end
    else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      sel = 4'b0110; d1 = a; d2 = b; res = a - b; isbr = 1;
      tk = (f3 == 3'b000) ? (a == b) : (a != b);
    end
    else ill = 1;
  endfunction

  task automatic run_one(input logic [6:0] op, input logic [2:0] f3, input logic b5,
      input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] im, input int stall);
    logic [3:0] e_sel; logic [N-1:0] e_d1, e_d2, e_res; logic e_br, e_tk, e_ill;
    ref_model(op, f3, b5, a, b, im, e_sel, e_d1, e_d2, e_res, e_br, e_tk, e_ill);
    @(negedge clk);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got %b exp 1", in_ready); end
    opcode = op; funct3 = f3; funct7_b5 = b5; rs1_val = a; rs2_val = b; imm = im;
    out_ready = (stall == 0); in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    total++;
    if ({alu_select, alu_data1, alu_data2} !== {e_sel, e_d1, e_d2}) begin
      bad++; $display("FAIL alu_issue got sel=%b d1=%h d2=%h exp sel=%b d1=%h d2=%h",
        alu_select, alu_data1, alu_data2, e_sel, e_d1, e_d2);
    end
    total++;
    if ({out_valid, in_ready} !== 2'b00) begin
      bad++; $display("FAIL exec_hs got vld/rdy=%b%b exp 00", out_valid, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_result, out_is_branch, out_br_taken, out_illegal} !==
        {1'b1, e_res, e_br, e_tk, e_ill}) begin
      bad++; $display("FAIL result got v=%b r=%h br=%b tk=%b il=%b exp v=1 r=%h br=%b tk=%b il=%b",
        out_valid, out_result, out_is_branch, out_br_taken, out_illegal, e_res, e_br, e_tk, e_ill);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, out_result} !== {2'b10, e_res}) begin
        bad++; $display("FAIL stall_hold got v=%b rdy=%b r=%h exp v=1 rdy=0 r=%h",
          out_valid, in_ready, out_result, e_res);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready, out_result, alu_select} !== {2'b01, e_res, e_sel}) begin
      bad++; $display("FAIL retire got v=%b rdy=%b r=%h sel=%b exp v=0 rdy=1 r=%h sel=%b",
        out_valid, in_ready, out_result, alu_select, e_res, e_sel);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid, out_is_branch, out_br_taken, out_illegal, alu_select,
         alu_data1, alu_data2, out_result} !== '0) begin
      bad++; $display("FAIL reset_state got rdy=%b v=%b sel=%b d1=%h d2=%h r=%h exp all 0",
        in_ready, out_valid, alu_select, alu_data1, alu_data2, out_result);
    end
    @(negedge clk); rst_n = 1; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release got %b exp 1", in_ready); end
  endtask

  task automatic test_radd();
    run_one(7'b0110011, 3'b000, 1'b0, 64'h7, 64'h5, 64'h0, 0);
  endtask

  task automatic test_branch();
    run_one(7'b1100011, 3'b000, 1'b0, 64'h1234, 64'h1234, 64'h0, 0);
    run_one(7'b1100011, 3'b001, 1'b0, 64'h1234, 64'h1234, 64'h0, 0);
    run_one(7'b1100011, 3'b001, 1'b0, 64'h1234, 64'h1235, 64'h0, 0);
  endtask

  task automatic test_lui_itype();
    run_one(7'b0110111, 3'b000, 1'b0, 64'hDEAD, 64'hBEEF, 64'hFFFF_FFFF_8000_0000, 0);
    run_one(7'b0010011, 3'b110, 1'b1, 64'hF0, 64'h0, 64'h0F, 0);
    run_one(7'b0000011, 3'b011, 1'b0, 64'h1000, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 1);
  endtask

  task automatic test_illegal();
    run_one(7'b0110011, 3'b001, 1'b0, 64'h55, 64'h66, 64'h77, 0);
    run_one(7'b1100011, 3'b100, 1'b0, 64'h5, 64'h5, 64'h0, 0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    opcode = 7'b0110011; funct3 = 3'b000; funct7_b5 = 0;
    rs1_val = 64'h10; rs2_val = 64'h20; out_ready = 0; in_valid = 1;
    @(posedge clk); #1;
    rs1_val = 64'h999;
    @(posedge clk); #1;
    for (int s = 0; s < 5; s++) begin
      total++;
      if ({out_valid, in_ready, out_result, alu_data1} !== {2'b10, 64'h30, 64'h10}) begin
        bad++; $display("FAIL bp_hold got v=%b rdy=%b r=%h d1=%h exp v=1 rdy=0 r=30 d1=10",
          out_valid, in_ready, out_result, alu_data1);
      end
      in_valid = ~in_valid; rs1_val = {$urandom, $urandom}; funct3 = 3'b111;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready, out_result} !== {2'b01, 64'h30}) begin
      bad++; $display("FAIL bp_release got v=%b rdy=%b r=%h exp v=0 rdy=1 r=30",
        out_valid, in_ready, out_result);
    end
    run_one(7'b0110011, 3'b000, 1'b1, 64'h100, 64'h1, 64'h0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    opcode = 7'b0110011; funct3 = 3'b000; funct7_b5 = 0;
    rs1_val = 64'hA; rs2_val = 64'hB; out_ready = 1; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    #2 rst_n = 0;
    #1;
    total++;
    if ({out_valid, in_ready, alu_select, alu_data1, alu_data2} !== '0) begin
      bad++; $display("FAIL reset_mid got v=%b rdy=%b sel=%b d1=%h d2=%h exp all 0",
        out_valid, in_ready, alu_select, alu_data1, alu_data2);
    end
    @(negedge clk); rst_n = 1; #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_mid_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    run_one(7'b0110011, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h0, 0);
  endtask

  task automatic test_random();
    logic [6:0] op; logic [2:0] f3; logic b5; logic [N-1:0] a, b, im;
    for (int t = 0; t < 40; t++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; im = {$urandom, $urandom};
      b5 = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 6))
        0, 1:    op = 7'b0110011;
        2:       op = 7'b0010011;
        3:       op = $urandom_range(0, 1) ? 7'b0000011 : 7'b0100011;
        4:       op = 7'b0110111;
        5:       begin op = 7'b1100011; f3 = 3'($urandom_range(0, 2)); if ($urandom_range(0, 1) == 1) b = a; end
        default: op = 7'($urandom);
      endcase
      run_one(op, f3, b5, a, b, im, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_radd();
    test_branch();
    test_lui_itype();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing front-end that drives the datapath ALU's operand and select interface and consumes its result and zero flag.
- Accepts one decoded RV64 integer instruction per handshake and translates opcode/funct fields into the 4-bit ALU select code.
- Applies registered operands, captures the combinational ALU response one cycle later, and presents a write-back result or branch decision through a valid/ready handshake.
- Sits between the decode stage and write-back/branch resolution.

Parameters:
- n, 64, datapath width of operands, immediate and result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction offered
- in_ready  output  1  block can accept an instruction
- opcode  input  7  instruction opcode field
- funct3  input  3  instruction funct3 field
- funct7_b5  input  1  instruction bit 30
- rs1_val  input  n  source register 1 value
- rs2_val  input  n  source register 2 value
- imm  input  n  immediate, already sign-extended by decode
- alu_data1  output  n  ALU operand 1 (registered)
- alu_data2  output  n  ALU operand 2 (registered)
- alu_select  output  4  ALU operation code (registered)
- alu_result  input  n  combinational ALU result
- alu_zero  input  1  ALU result-is-zero flag
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  n  captured ALU result
- out_is_branch  output  1  instruction was a branch
- out_br_taken  output  1  branch condition true
- out_illegal  output  1  unsupported encoding

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on rst_n, clocked by clk.
  - While rst_n is low: state IDLE; alu_data1, alu_data2, alu_select, out_result = 0; out_valid, out_is_branch, out_br_taken, out_illegal = 0; in_ready forced 0.
- ALU select codes: AND 0000, OR 0001, ADD 0010, SUB 0110, PASS-data2 0111, NOR 1100. NOR is never issued.
- Decode (operands are data1, data2):
  - 0110011 (R-type):
    - f3=000, b5=0: ADD rs1, rs2.
    - f3=000, b5=1: SUB rs1, rs2.
    - f3=111: AND.
    - f3=110: OR.
  - 0010011 (I-type):
    - f3=000: ADD rs1, imm.
    - f3=111: AND rs1, imm.
    - f3=110: OR rs1, imm.
    - funct7_b5 is ignored.
  - 0000011 / 0100011 (load/store address): ADD rs1, imm.
  - 0110111 (LUI): PASS, data1=0, data2=imm.
  - 1100011 (branch): SUB rs1, rs2.
    - f3=000 BEQ: taken = alu_zero.
    - f3=001 BNE: taken = !alu_zero.
  - Any other combination is illegal: PASS, data1=0, data2=0, out_illegal=1, result 0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready, register decoded select and operands, latch is_branch/branch-type/illegal, then go to EXEC. Without in_valid, stay in IDLE.
  - EXEC: in_ready=0; ALU inputs are stable from the registers.
    - On the clock edge: out_result <= alu_result; out_br_taken per the branch type (0 for non-branch and illegal); out_is_branch and out_illegal loaded; out_valid <= 1; go to DONE.
  - DONE: in_ready=0; all out_* held stable.
    - When out_ready=1: out_valid <= 0 and go to IDLE.
    - While out_ready=0: hold indefinitely.
- Latency and throughput:
  - Handshake accepted at edge k gives out_valid high after edge k+1.
  - With out_ready held 1, in_ready returns high after edge k+2.
  - Peak throughput is 1 instruction per 3 cycles.
- Between transactions:
  - alu_* outputs keep their last values after EXEC; they change only on a new acceptance.
  - out_result and flags keep their last values while out_valid=0.
- out_ready while out_valid=0 is ignored.
- in_valid is ignored outside IDLE; the producer must hold its instruction until it sees in_ready.
- Reset asserted mid-transaction (EXEC or DONE) discards the transaction immediately; no output is produced after release.
- Width: all arithmetic is performed in the ALU at n bits; the block never extends or truncates operands.

Test Plan:
- R-type ADD:
  - Stimulus: rs1=0x7, rs2=0x5, op 0110011, f3=000, b5=0, out_ready=1.
  - Response: alu_select=0010; out_result=0xC one cycle after acceptance; out_is_branch=0; out_illegal=0; in_ready high again 2 cycles after acceptance.
- BEQ:
  - Stimulus: rs1=rs2=0x1234, op 1100011, f3=000.
  - Response: alu_select=0110; out_result=0; out_is_branch=1; out_br_taken=1.
  - Repeat with f3=001 (BNE): out_br_taken=0.
- LUI and I-type:
  - LUI with imm=0xFFFF_FFFF_8000_0000: alu_data1=0, alu_select=0111, out_result=imm.
  - ORI with rs1=0xF0, imm=0x0F: select 0001, out_result=0xFF.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, toggling in_valid with a new instruction throughout.
  - Response: outputs stable, in_ready=0, no second acceptance; accepted only after out_ready=1 and return to IDLE.
- Illegal encoding:
  - Stimulus: op 0110011, f3=001.
  - Response: out_illegal=1, out_result=0, out_br_taken=0, alu_select=0111.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while in EXEC.
  - Response: out_valid, alu_select, alu_data1/2 go to 0 without a clock edge; after release in_ready=1 and the next ADD completes normally.
